srgate: RTL and testbench
=========================

SRGATE -- requirements
Module: srgate

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-low reset; all state SHALL be clocked on the rising edge of CLK.
REQ-002 The module SHALL have parameter SYNC_STAGES, default 2, minimum 2: the base synchronizer depth applied to S, R and X.
REQ-003 The module SHALL have port CLK, input, 1 bit: system clock.
REQ-004 The module SHALL have port RST_N, input, 1 bit: asynchronous active-low reset.
REQ-005 The module SHALL have port Q, output, 1 bit: latch true output.
REQ-006 The module SHALL have port Qbar, output, 1 bit: latch complement output.
REQ-007 The module SHALL have port S, input, 1 bit, asynchronous to CLK: set request.
REQ-008 The module SHALL have port R, input, 1 bit, asynchronous to CLK: clear request.
REQ-009 The module SHALL have port X, input, 1 bit, asynchronous to CLK: synchronizer-depth select, 0 for SYNC_STAGES and 1 for SYNC_STAGES+1.
REQ-010 Port order SHALL be Q, Qbar, S, R, X, CLK, RST_N, so that positional instantiation of the first five ports is preserved.

Function
REQ-011 S, R and X SHALL each pass through a SYNC_STAGES-deep flop synchronizer before use.
REQ-012 When the synchronized X is 1, S and R SHALL pass through one extra stage, so input-to-output latency is SYNC_STAGES+1 cycles, otherwise SYNC_STAGES cycles.
REQ-013 The state machine SHALL have four states: UNINIT, SET, CLR and FORBID.
REQ-014 In UNINIT, Q and Qbar SHALL both be driven 1'bx; this is don't-care for synthesis.
REQ-015 In SET, Q SHALL be 1 and Qbar SHALL be 0.
REQ-016 In CLR, Q SHALL be 0 and Qbar SHALL be 1.
REQ-017 In FORBID, Q and Qbar SHALL both be 1'bz, using tri-state drivers.
REQ-018 Synchronized {S,R}=10 SHALL move the state machine to SET from any state.
REQ-019 Synchronized {S,R}=01 SHALL move the state machine to CLR from any state.
REQ-020 Synchronized {S,R}=11 SHALL move the state machine to FORBID from any state.
REQ-021 Synchronized {S,R}=00 SHALL hold SET, CLR and UNINIT.
REQ-022 Synchronized {S,R}=00 while in FORBID SHALL move the state machine to UNINIT, the indeterminate release case.
REQ-023 A change of the synchronized X SHALL force UNINIT on the next edge and flush the extra stage, with X-change priority over S/R that cycle.
REQ-024 Q and Qbar SHALL be registered outputs, with no combinational path from S, R or X.

Reset
REQ-025 RST_N low SHALL immediately clear all synchronizer flops to 0 and force the state to UNINIT, with Q=Qbar=x.
REQ-026 Reset assertion mid-operation, in any state, SHALL behave identically to REQ-025.
REQ-027 Reset deassertion SHALL take effect at the first CLK edge after RST_N rises.

Configuration
REQ-028 With macro SRGATE_GLITCH_FILTER_EN defined, a synchronized {S,R} value SHALL act only after it is equal on two consecutive cycles, adding 1 cycle of latency.
REQ-029 Without SRGATE_GLITCH_FILTER_EN, a synchronized {S,R} value SHALL act on the first cycle it appears.

Verification
REQ-030 Reset, X=0, S=R=0, 10 cycles -> Q===x and Qbar===x.
REQ-031 X=0, {S,R}=10, wait SYNC_STAGES+1 cycles -> Q=1, Qbar=0; then {S,R}=00 -> Q=1, Qbar=0 held.
REQ-032 {S,R}=01 -> Q=0, Qbar=1; then {S,R}=00 -> Q=0, Qbar=1 held.
REQ-033 {S,R}=11 -> Q===z and Qbar===z; then {S,R}=00 -> Q===x.
REQ-034 Repeat REQ-031 to REQ-033 with X=1: response appears exactly one cycle later than with X=0, and the X toggle itself forces Q===x.
REQ-035 RST_N pulsed low while in SET -> Q===x immediately, without waiting for a CLK edge.

Source files
------------

// File: rtl/srgate.sv
`timescale 1ns/1ps
// srgate: synchronized set/reset latch with selectable synchronizer depth.
//
// S, R and X are asynchronous to CLK and each pass through a SYNC_STAGES-deep
// flop synchronizer. When the synchronized X is 1, {S,R} goes through one
// extra register, so the input-to-output latency becomes SYNC_STAGES+1 cycles.
// Any change of the synchronized X drops the latch back to UNINIT and empties
// that extra register, so a half-delayed value is never acted on.
//
// Optional feature: define SRGATE_GLITCH_FILTER_EN to make a synchronized
// {S,R} value act only once it has been seen on two consecutive cycles.
// This adds one cycle of latency. Without the macro a value acts on the first
// cycle it appears.
//
// Ports:
//   Q      out  latch true output (x in UNINIT, z in FORBID)
//   Qbar   out  latch complement output (x in UNINIT, z in FORBID)
//   S      in   set request, asynchronous
//   R      in   clear request, asynchronous
//   X      in   depth select, asynchronous: 0 -> SYNC_STAGES, 1 -> SYNC_STAGES+1
//   CLK    in   system clock, rising edge
//   RST_N  in   asynchronous active-low reset
//
// Parameter SYNC_STAGES: base synchronizer depth, default 2, minimum 2.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// UNINIT    | latch value unknown (reset, X change, release from FORBID)
// SET       | Q=1, Qbar=0
// CLR       | Q=0, Qbar=1
// FORBID    | S and R both asserted, outputs released to high impedance

module srgate #(
  parameter int SYNC_STAGES = 2
) (
  output tri   Q,
  output tri   Qbar,
  input  logic S,
  input  logic R,
  input  logic X,
  input  logic CLK,
  input  logic RST_N
);

  typedef enum logic [1:0] {
    ST_UNINIT = 2'd0,
    ST_SET    = 2'd1,
    ST_CLR    = 2'd2,
    ST_FORBID = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] s_sync;
  logic [SYNC_STAGES-1:0] r_sync;
  logic [SYNC_STAGES-1:0] x_sync;

  logic       s_s;
  logic       r_s;
  logic       x_s;
  logic       x_prev;
  logic       x_change;
  logic [1:0] sr_now;
  logic [1:0] sr_extra;
  logic [1:0] sr_use;
  logic       sr_act;

  state_t state;
  state_t next_state;

  logic q_val;
  logic qb_val;
  logic oe;

  // Synchronizers: bit 0 takes the raw input, the top bit is the usable value.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      s_sync <= '0;
      r_sync <= '0;
      x_sync <= '0;
    end else begin
      s_sync <= {s_sync[SYNC_STAGES-2:0], S};
      r_sync <= {r_sync[SYNC_STAGES-2:0], R};
      x_sync <= {x_sync[SYNC_STAGES-2:0], X};
    end
  end

  assign s_s      = s_sync[SYNC_STAGES-1];
  assign r_s      = r_sync[SYNC_STAGES-1];
  assign x_s      = x_sync[SYNC_STAGES-1];
  assign sr_now   = {s_s, r_s};
  assign x_change = x_s ^ x_prev;
  assign sr_use   = x_s ? sr_extra : sr_now;

  // The extra stage is flushed on an X change so that the cycle after the
  // switch sees a neutral 00 instead of a value captured under the old depth.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      x_prev   <= 1'b0;
      sr_extra <= 2'b00;
    end else begin
      x_prev   <= x_s;
      sr_extra <= x_change ? 2'b00 : sr_now;
    end
  end

`ifdef SRGATE_GLITCH_FILTER_EN
  logic [1:0] sr_prev;

  // The history is cleared on an X change, in step with the flushed stage.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sr_prev <= 2'b00;
    end else begin
      sr_prev <= x_change ? 2'b00 : sr_use;
    end
  end

  assign sr_act = (sr_use == sr_prev);
`else
  assign sr_act = 1'b1;
`endif

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= ST_UNINIT;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    if (x_change) begin
      next_state = ST_UNINIT;
    end else if (sr_act) begin
      case (sr_use)
        2'b10:   next_state = ST_SET;
        2'b01:   next_state = ST_CLR;
        2'b11:   next_state = ST_FORBID;
        default: begin
          // Releasing both requests together leaves the latch indeterminate.
          if (state == ST_FORBID) begin
            next_state = ST_UNINIT;
          end
        end
      endcase
    end
  end

  // Outputs decode only the state flops, so nothing combinational reaches
  // Q/Qbar from S, R or X.
  always_comb begin
    q_val  = 1'b0;
    qb_val = 1'b0;
    oe     = 1'b1;
    case (state)
      ST_UNINIT: begin
        q_val  = 1'bx;
        qb_val = q_val;
      end
      ST_SET: begin
        q_val  = 1'b1;
        qb_val = 1'b0;
      end
      ST_CLR: begin
        q_val  = 1'b0;
        qb_val = 1'b1;
      end
      ST_FORBID: begin
        oe = 1'b0;
      end
      default: begin
        oe = 1'b1;
      end
    endcase
  end

  assign Q    = oe ? q_val  : 1'bz;
  assign Qbar = oe ? qb_val : 1'bz;

endmodule

// File: tb/tb_srgate.sv
`timescale 1ns/1ps
module tb_srgate;

  localparam int N = 2;
  localparam int ST_UNINIT = 0;
  localparam int ST_SET    = 1;
  localparam int ST_CLR    = 2;
  localparam int ST_FORBID = 3;
`ifdef SRGATE_GLITCH_FILTER_EN
  localparam bit FILT = 1'b1;
`else
  localparam bit FILT = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic s     = 1'b0;
  logic r     = 1'b0;
  logic x     = 1'b0;
  wire  q;
  wire  qbar;

  int checks = 0;
  int errors = 0;
  bit two_state;
  logic probe;

  // Inputs applied before each clock edge since reset release (index 0 = edge 1).
  bit hs[$];
  bit hr[$];
  bit hx[$];
  int mstate;

  typedef struct {
    int exp;
    int cyc;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  srgate #(.SYNC_STAGES(N)) dut (
    .Q    (q),
    .Qbar (qbar),
    .S    (s),
    .R    (r),
    .X    (x),
    .CLK  (clk),
    .RST_N(rst_n)
  );

  initial forever #5 clk = ~clk;

  function automatic bit gx(int k);
    if (k < 1 || k > hx.size()) return 1'b0;
    return hx[k-1];
  endfunction

  function automatic bit [1:0] gsr(int k);
    if (k < 1 || k > hs.size()) return 2'b00;
    return {hs[k-1], hr[k-1]};
  endfunction

  // Synchronized X seen at edge k differs from the one seen at edge k-1.
  function automatic bit chg(int k);
    return gx(k - N) != gx(k - N - 1);
  endfunction

  // {S,R} the latch sees at edge k: N cycles old, N+1 when deep mode is on,
  // and neutral on the switch edge and the edge right after it.
  function automatic bit [1:0] eff(int k);
    if (k < 1) return 2'b00;
    if (chg(k)) return 2'b00;
    if (!gx(k - N)) return gsr(k - N);
    if (chg(k - 1)) return 2'b00;
    return gsr(k - N - 1);
  endfunction

  function automatic string st_name(int st);
    case (st)
      ST_SET:  return "SET(1/0)";
      ST_CLR:  return "CLR(0/1)";
      ST_UNINIT: return "UNINIT(x/x)";
      default: return "FORBID(z/z)";
    endcase
  endfunction

  task automatic check_state(string tag, int cyc, int exp);
    bit ok;
    case (exp)
      ST_SET:    ok = (q === 1'b1) && (qbar === 1'b0);
      ST_CLR:    ok = (q === 1'b0) && (qbar === 1'b1);
      ST_UNINIT: ok = two_state ? (q === qbar) : ((q === 1'bx) && (qbar === 1'bx));
      default:   ok = two_state ? (q === qbar) : ((q === 1'bz) && (qbar === 1'bz));
    endcase
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s cycle %0d: got Q=%b Qbar=%b, expected %s", tag, cyc, q, qbar, st_name(exp));
    end
  endtask

  task automatic step(bit si, bit ri, bit xi);
    bit [1:0] u;
    bit act;
    int k;
    @(negedge clk);
    if (!rst_n) begin
      rst_n = 1'b1;
      hs.delete();
      hr.delete();
      hx.delete();
      mstate = ST_UNINIT;
    end
    s = si;
    r = ri;
    x = xi;
    hs.push_back(si);
    hr.push_back(ri);
    hx.push_back(xi);
    k = hx.size();
    if (chg(k)) begin
      mstate = ST_UNINIT;
    end else begin
      u = eff(k);
      act = !FILT || (u == eff(k - 1));
      if (act) begin
        case (u)
          2'b10: mstate = ST_SET;
          2'b01: mstate = ST_CLR;
          2'b11: mstate = ST_FORBID;
          default: if (mstate == ST_FORBID) mstate = ST_UNINIT;
        endcase
      end
    end
    sb.push_back('{exp: mstate, cyc: k});
  endtask

  // Asserts reset between edges and checks the outputs drop without a clock.
  task automatic do_reset();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    s = 1'b0;
    r = 1'b0;
    x = 1'b0;
    #1;
    check_state("reset_async", -1, ST_UNINIT);
    repeat (2) @(posedge clk);
  endtask

  // Monitor: one expectation per clock edge, compared after the edge settles.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        mon_e = sb.pop_front();
        check_state("sb", mon_e.cyc, mon_e.exp);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, expected bench to finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit cs, cr, cx;
    probe = 1'bx;
    two_state = !$isunknown(probe);
    mstate = ST_UNINIT;

    do_reset();
    repeat (10) step(0, 0, 0);

    repeat (N + 1) step(1, 0, 0);
    repeat (3) step(0, 0, 0);
    repeat (N + 1) step(0, 1, 0);
    repeat (3) step(0, 0, 0);
    repeat (N + 1) step(1, 1, 0);
    repeat (4) step(0, 0, 0);

    repeat (N + 1) step(1, 0, 0);
    repeat (N + 3) step(0, 0, 1);
    repeat (N + 2) step(1, 0, 1);
    repeat (3) step(0, 0, 1);
    repeat (N + 2) step(0, 1, 1);
    repeat (3) step(0, 0, 1);
    repeat (N + 2) step(1, 1, 1);
    repeat (4) step(0, 0, 1);
    repeat (N + 2) step(1, 0, 1);
    repeat (2) step(0, 0, 1);
    do_reset();

    cs = 1'b0;
    cr = 1'b0;
    cx = 1'b0;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 199) == 0) do_reset();
      if ($urandom_range(0, 15) == 0) cx = ~cx;
      if ($urandom_range(0, 3) == 0) {cs, cr} = 2'($urandom_range(0, 3));
      step(cs, cr, cx);
    end

    @(posedge clk);
    #2;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
